// File: rtl/light_row.sv
// light_row: a row of N lights with one lit position that two players push
// left (L key) or right (R key). Running off an end wins the round unless
// WRAP is set, in which case the light wraps to the opposite end.
module light_row #(
  parameter int N    = 9,
  parameter int WRAP = 0,
  parameter int SW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          res,
  input  logic          L,
  input  logic          R,
  output logic [N-1:0]  lights,
  output logic [1:0]    winner,
  output logic [SW-1:0] scoreL,
  output logic [SW-1:0] scoreR
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] CENTRE = PW'((N - 1) / 2);
  localparam logic [PW-1:0] LEFT_END = PW'(N - 1);
  localparam logic [SW-1:0] SCORE_MAX = {SW{1'b1}};

  typedef enum logic [1:0] {
    PLAY  = 2'b00,
    WIN_L = 2'b01,
    WIN_R = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pos, pos_nxt;
  logic [SW-1:0] score_l_nxt, score_r_nxt;
  logic          l_q, r_q;
  logic          press_l, press_r;

  // Key history resets high so a key already held at release is not a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_q <= 1'b1;
      r_q <= 1'b1;
    end else begin
      l_q <= L;
      r_q <= R;
    end
  end

  assign press_l = L & ~l_q;
  assign press_r = R & ~r_q;

  // Round state, light position and scores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= PLAY;
      pos    <= CENTRE;
      scoreL <= '0;
      scoreR <= '0;
    end else begin
      state  <= state_nxt;
      pos    <= pos_nxt;
      scoreL <= score_l_nxt;
      scoreR <= score_r_nxt;
    end
  end

  // Next state: restart beats everything; only a lone press moves the light.
  always_comb begin
    state_nxt   = state;
    pos_nxt     = pos;
    score_l_nxt = scoreL;
    score_r_nxt = scoreR;
    if (res) begin
      state_nxt = PLAY;
      pos_nxt   = CENTRE;
    end else if (state == PLAY) begin
      if (press_l && !press_r) begin
        if (pos != LEFT_END) begin
          pos_nxt = pos + PW'(1);
        end else if (WRAP != 0) begin
          pos_nxt = '0;
        end else begin
          state_nxt = WIN_L;
          if (scoreL != SCORE_MAX) score_l_nxt = scoreL + SW'(1);
        end
      end else if (press_r && !press_l) begin
        if (pos != '0) begin
          pos_nxt = pos - PW'(1);
        end else if (WRAP != 0) begin
          pos_nxt = LEFT_END;
        end else begin
          state_nxt = WIN_R;
          if (scoreR != SCORE_MAX) score_r_nxt = scoreR + SW'(1);
        end
      end
    end
  end

  // Outputs decode only registered state, never the key or restart inputs.
  always_comb begin
    lights = '0;
    winner = 2'b00;
    case (state)
      PLAY:    lights = N'(1) << pos;
      WIN_L:   winner = 2'b01;
      WIN_R:   winner = 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_light_row.sv
// tb_light_row: drives a game-mode and a wrap-mode light_row from the same
// keys and compares both against a position/score model of the game rules.
module tb_light_row;

  localparam int N  = 9;
  localparam int SW = 3;
  localparam int C  = (N - 1) / 2;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic reset, res, L, R;
  logic [N-1:0]  lights0, lights1;
  logic [1:0]    winner0, winner1;
  logic [SW-1:0] scoreL0, scoreR0, scoreL1, scoreR1;

  int total = 0;
  int bad   = 0;

  // model: index 0 is the game-mode board, index 1 the wrap-mode board
  int   mPos[2];
  int   mWin[2];
  int   mScL[2];
  int   mScR[2];
  logic mPrevL, mPrevR;

  always #5 clk = ~clk;

  light_row #(.N(N), .WRAP(0), .SW(SW)) dut (
    .clk(clk), .reset(reset), .res(res), .L(L), .R(R),
    .lights(lights0), .winner(winner0), .scoreL(scoreL0), .scoreR(scoreR0)
  );

  light_row #(.N(N), .WRAP(1), .SW(SW)) dutW (
    .clk(clk), .reset(reset), .res(res), .L(L), .R(R),
    .lights(lights1), .winner(winner1), .scoreL(scoreL1), .scoreR(scoreR1)
  );

  task automatic checkValue(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      mPos[m] = C;
      mWin[m] = 0;
      mScL[m] = 0;
      mScR[m] = 0;
    end
    mPrevL = 1'b1;
    mPrevR = 1'b1;
  endtask

  task automatic modelStep(input logic l, input logic r, input logic rs);
    bit pl, pr;
    int target;
    pl = l && !mPrevL;
    pr = r && !mPrevR;
    for (int m = 0; m < 2; m++) begin
      if (rs) begin
        mPos[m] = C;
        mWin[m] = 0;
      end else if (mWin[m] == 0 && pl != pr) begin
        target = pl ? mPos[m] + 1 : mPos[m] - 1;
        if (target >= 0 && target < N) mPos[m] = target;
        else if (m == 1) mPos[m] = (target + N) % N;
        else if (pl) begin
          mWin[m] = 1;
          if (mScL[m] < SMAX) mScL[m] = mScL[m] + 1;
        end else begin
          mWin[m] = 2;
          if (mScR[m] < SMAX) mScR[m] = mScR[m] + 1;
        end
      end
    end
    mPrevL = l;
    mPrevR = r;
  endtask

  task automatic checkOutput(input string tag);
    int expLights;
    for (int m = 0; m < 2; m++) begin
      expLights = (mWin[m] == 0) ? (1 << mPos[m]) : 0;
      checkValue({tag, m ? " w.lights" : " g.lights"},
                 m ? int'(lights1) : int'(lights0), expLights);
      checkValue({tag, m ? " w.winner" : " g.winner"},
                 m ? int'(winner1) : int'(winner0), mWin[m]);
      checkValue({tag, m ? " w.scoreL" : " g.scoreL"},
                 m ? int'(scoreL1) : int'(scoreL0), mScL[m]);
      checkValue({tag, m ? " w.scoreR" : " g.scoreR"},
                 m ? int'(scoreR1) : int'(scoreR0), mScR[m]);
    end
  endtask

  // one clock: drive inputs well before the edge, model the edge, check after
  task automatic applyStimulus(input logic l, input logic r, input logic rs, input string tag);
    L = l;
    R = r;
    res = rs;
    @(posedge clk);
    modelStep(l, r, rs);
    #1;
    checkOutput(tag);
  endtask

  task automatic pulse(input logic l, input logic r, input string tag);
    applyStimulus(l, r, 1'b0, tag);
    applyStimulus(1'b0, 1'b0, 1'b0, tag);
  endtask

  // raise reset between edges and check the cleared outputs before any edge
  task automatic asyncReset(input string tag);
    reset = 1'b1;
    #2;
    modelReset();
    checkOutput(tag);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    res = 1'b0;
    L = 1'b1;
    R = 1'b0;
    #12;
    modelReset();
    checkOutput("in_reset");
    reset = 1'b0;
    checkValue("reset lights", int'(lights0), 'h010);

    // key held across reset release is not a press
    applyStimulus(1'b1, 1'b0, 1'b0, "held_over_reset");
    checkValue("held lights", int'(lights0), 'h010);
    applyStimulus(1'b0, 1'b0, 1'b0, "release");

    // single L pulse
    applyStimulus(1'b1, 1'b0, 1'b0, "l_pulse");
    checkValue("l_pulse lights", int'(lights0), 'h020);
    checkValue("l_pulse winner", int'(winner0), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, "l_pulse_low");

    // L held six cycles gives one step
    applyStimulus(1'b0, 1'b0, 1'b1, "res");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, "l_held");
    checkValue("l_held lights", int'(lights0), 'h020);
    applyStimulus(1'b0, 1'b0, 1'b0, "l_release");
    applyStimulus(1'b1, 1'b1, 1'b0, "both_rise");
    checkValue("both lights", int'(lights0), 'h020);
    applyStimulus(1'b0, 1'b0, 1'b0, "both_release");

    // five L pulses from centre: left wins
    applyStimulus(1'b0, 1'b0, 1'b1, "res");
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, "l_run");
    checkValue("l_win winner", int'(winner0), 1);
    checkValue("l_win lights", int'(lights0), 0);
    checkValue("l_win scoreL", int'(scoreL0), 1);
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, "ignored_r");
    applyStimulus(1'b0, 1'b0, 1'b1, "res_after_win");
    checkValue("res lights", int'(lights0), 'h010);
    checkValue("res scoreL", int'(scoreL0), 1);

    // second left win, then reset between edges while in WIN_L
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, "l_run2");
    checkValue("l_win2 scoreL", int'(scoreL0), 2);
    asyncReset("async_in_win");
    checkValue("async scoreL", int'(scoreL0), 0);
    checkValue("async lights", int'(lights0), 'h010);

    // eight right wins saturate the score
    for (int w = 0; w < 8; w++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, "res");
      for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, "r_run");
    end
    checkValue("sat scoreR", int'(scoreR0), SMAX);
    checkValue("sat winner", int'(winner0), 2);

    // wrap board: five R pulses from centre land on the left end
    applyStimulus(1'b0, 1'b0, 1'b1, "res");
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, "wrap_run");
    checkValue("wrap lights", int'(lights1), 'h100);
    checkValue("wrap winner", int'(winner1), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, "res_with_r");
    checkValue("res_r lights", int'(lights1), 'h010);
    applyStimulus(1'b0, 1'b1, 1'b0, "r_held_after_res");
    checkValue("r_held lights", int'(lights1), 'h010);
    applyStimulus(1'b0, 1'b0, 1'b0, "release");

    // random play on both boards
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) asyncReset("rand_reset");
      else applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 19) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
